if_prefetch_queue: RTL and testbench
====================================

Name: if_prefetch_queue

Overview:
Instruction-fetch front end between the instruction-memory SRAM_wrapper and the CPU decode stage. It drives the IM word address, absorbs the SRAM's one-cycle read latency, and buffers fetched instructions with their PCs in a small FIFO. It presents them to decode through a valid/ready handshake and flushes on branch/jump redirect.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
im_a  out  14  IM word address, equal to fetch byte address [15:2]; connects to SRAM_wrapper A
im_do  in  32  IM read data; valid the cycle after the address is sampled
redirect_valid  in  1  flush the queue and restart fetch at redirect_pc
redirect_pc  in  32  redirect target byte address; bits [1:0] ignored
deq_valid  out  1  head entry available
deq_ready  in  1  decode accepts the head entry
deq_instr  out  32  head instruction
deq_pc  out  32  head byte PC
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- State:
  - fetch_pc[31:0]: next address to issue.
  - issued_q (1b) and issued_pc_q[31:0]: request in flight.
  - FIFO of {instr, pc} with head/tail pointers and count.
- Reset (rst low, async): fetch_pc=RESET_PC, issued_q=0, count=0, pointers=0. Outputs during reset: deq_valid=0, count=0, im_a=RESET_PC[15:2]. deq_instr and deq_pc read 0.
- im_a is combinational:
  - redirect_valid=1: im_a = redirect_pc[15:2].
  - otherwise: im_a = fetch_pc[15:2].
  - When no request issues, im_a holds fetch_pc and the returned data is ignored.
- Issue (normal cycle):
  - Issue when count + issued_q < DEPTH. This reserves space; same-cycle dequeue is not credited.
  - On issue: issued_q<=1, issued_pc_q<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32).
  - No issue: issued_q<=0.
- Return: in the cycle after an issue (issued_q=1, no redirect), push {im_do, issued_pc_q} into the FIFO at the end of that cycle.
- Latency: issue in cycle t, data on im_do in t+1, deq_valid in t+2. There is no bypass.
- Throughput: 1 instruction/cycle when decode is always ready.
- Dequeue:
  - deq_valid = (count!=0) && !redirect_valid.
  - A handshake occurs when deq_valid && deq_ready; the head then advances.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by construction. An assertion checks count <= DEPTH.
- Redirect (redirect_valid=1) has priority over all other events in that cycle:
  - count<=0 and pointers reset.
  - In-flight data returning this cycle is discarded, with no push.
  - Any deq_ready is ignored.
  - A new request issues unconditionally at redirect_pc & ~3: issued_q<=1, issued_pc_q<=redirect_pc&~3, fetch_pc<=(redirect_pc&~3)+4.
- Redirect on consecutive cycles: the last one wins. Each earlier one is discarded by the next flush.
- Address wrap: im_a uses fetch_pc[15:2], so it wraps from 0x3FFF to 0x0000. deq_pc carries the full 32-bit PC.
- Reset mid-operation: all entries and the in-flight request are lost. Fetch resumes at RESET_PC on the first edge after rst rises.

Test Plan:
- Reset release, IM word n = 0x1000_0000+n, deq_ready=1:
  - deq_valid first rises in the 2nd cycle after release.
  - deq_pc = 0,4,8,… with instr 0x1000_0000, _0001, _0002, one per cycle, no bubbles.
- deq_ready=0 from reset:
  - count saturates at 4 (entries pc 0x0–0xC) and im_a holds 0x0004.
  - Raise deq_ready: pcs 0x0,0x4,0x8,0xC,0x10 are delivered in order with no loss or duplicate.
- Queue full, redirect_valid=1 with redirect_pc=0x0000_0103:
  - That cycle: im_a=0x0040 and deq_valid=0.
  - Next cycle: count=0.
  - Two cycles after redirect: deq_pc=0x100 with IM word 0x40. Old entries never appear.
- Redirect asserted exactly in the cycle a fetch for pc 0x8 returns: that instruction is never pushed, and the next deq_pc is the redirect target.
- rst driven low asynchronously between clock edges while count=3:
  - deq_valid and count go to 0 immediately, without waiting for a clock.
  - im_a = RESET_PC[15:2].
  - After release, fetch restarts at RESET_PC.
- Redirect to 0x0000_FFFC, deq_ready=1:
  - im_a = 0x3FFF then 0x0000.
  - deq_pc = 0x0000_FFFC then 0x0001_0000.

Source files
------------

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_queue
// Description : Instruction-fetch front end. It drives the instruction-memory
//               word address and absorbs the one-cycle SRAM read latency.
//               Fetched {instr, pc} pairs are buffered in a small FIFO and
//               offered to decode through a valid/ready handshake. A redirect
//               flushes the FIFO and restarts fetch at the new target.
// Ports       : clk            - clock, rising edge
//               rst            - asynchronous reset, active low
//               im_a           - IM word address (fetch byte address [15:2])
//               im_do          - IM read data, valid the cycle after im_a
//               redirect_valid - flush and restart fetch at redirect_pc
//               redirect_pc    - redirect byte address, bits [1:0] ignored
//               deq_valid      - head entry available
//               deq_ready      - decode accepts the head entry
//               deq_instr      - head instruction
//               deq_pc         - head byte PC
//               count          - occupied FIFO entries
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [13:0]                im_a,
  input  logic [31:0]                im_do,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [31:0]                deq_instr,
  output logic [31:0]                deq_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic          issued_q;
  logic [31:0]   issued_pc_q;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic [31:0]   redirect_pc_al;
  logic [CW:0]   reserved;
  logic          issue;
  logic          push;
  logic          pop;
  logic          unused_redirect_lsbs;

  assign redirect_pc_al       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Space is reserved for the in-flight request so a returning word always
  // has a slot; a same-cycle dequeue is deliberately not credited.
  assign reserved = {1'b0, count} + {{CW{1'b0}}, issued_q};
  assign issue    = reserved < (CW+1)'(DEPTH);

  // Data returning during a redirect belongs to the abandoned path.
  assign push = issued_q & ~redirect_valid;
  assign pop  = deq_valid & deq_ready;

  assign im_a      = redirect_valid ? redirect_pc[15:2] : fetch_pc[15:2];
  assign deq_valid = (count != '0) && !redirect_valid;
  // Gated on occupancy so the outputs read zero when empty and under reset.
  assign deq_instr = (count != '0) ? fifo_instr[head] : 32'd0;
  assign deq_pc    = (count != '0) ? fifo_pc[head]    : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      issued_q    <= 1'b0;
      issued_pc_q <= 32'd0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      // Redirect overrides every other event and issues the target fetch.
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      issued_q    <= 1'b1;
      issued_pc_q <= redirect_pc_al;
      fetch_pc    <= redirect_pc_al + 32'd4;
    end else begin
      if (issue) begin
        issued_q    <= 1'b1;
        issued_pc_q <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end else begin
        issued_q    <= 1'b0;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[tail] <= im_do;
      fifo_pc[tail]    <= issued_pc_q;
    end
  end

  count_bound: assert property (@(posedge clk) disable iff (!rst)
                                count <= CW'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_queue
// Description : Directed self-checking bench for if_prefetch_queue. A simple
//               SRAM model returns 0x1000_0000 + word address one cycle after
//               the address is sampled. Inputs change and outputs are sampled
//               just after the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] im_a;
  logic [31:0] im_do = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_instr;
  logic [31:0] deq_pc;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Instruction memory: word n holds 0x1000_0000 + n, one-cycle latency.
  always_ff @(posedge clk) im_do <= 32'h1000_0000 + {18'd0, im_a};

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .im_a           (im_a),
    .im_do          (im_do),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_instr      (deq_instr),
    .deq_pc         (deq_pc),
    .count          (count)
  );

  // Pulse reset for one cycle and release it just after a falling edge.
  task automatic do_reset(input logic ready);
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    deq_ready      = ready;
    rst            = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; deq_ready = 1'b0; redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", deq_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (im_a !== 14'h0) begin bad++; $display("FAIL reset_im_a: got %h want 0000", im_a); end
    total++; if (deq_instr !== 32'd0) begin bad++; $display("FAIL reset_instr: got %h want 0", deq_instr); end
    total++; if (deq_pc !== 32'd0) begin bad++; $display("FAIL reset_pc: got %h want 0", deq_pc); end
  endtask

  task automatic test_stream;
    deq_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL stream_first_cycle_valid: got %b want 0", deq_valid); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, deq_valid); end
      total++; if (deq_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, deq_pc, 32'(4 * i)); end
      total++; if (deq_instr !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, deq_instr, 32'h1000_0000 + 32'(i)); end
    end
  endtask

  task automatic test_full_then_drain;
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", count); end
    total++; if (im_a !== 14'h0004) begin bad++; $display("FAIL full_im_a: got %h want 0004", im_a); end
    deq_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d]: got %b want 1", i, deq_valid); end
      total++; if (deq_pc !== 32'(4 * i)) begin bad++; $display("FAIL drain_pc[%0d]: got %h want %h", i, deq_pc, 32'(4 * i)); end
      total++; if (deq_instr !== 32'h1000_0000 + 32'(i)) begin bad++; $display("FAIL drain_instr[%0d]: got %h want %h", i, deq_instr, 32'h1000_0000 + 32'(i)); end
      @(negedge clk); #1;
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_redirect_full;
    repeat (6) @(negedge clk);
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("FAIL refill_count: got %0d want 4", count); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; deq_ready = 1'b1;
    #1;
    total++; if (im_a !== 14'h0040) begin bad++; $display("FAIL redir_im_a: got %h want 0040", im_a); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL redir_valid: got %b want 0", deq_valid); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL redir_count: got %0d want 0", count); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL redir_next_valid: got %b want 0", deq_valid); end
    @(negedge clk); #1;
    total++; if (deq_pc !== 32'h100) begin bad++; $display("FAIL redir_pc0: got %h want 00000100", deq_pc); end
    total++; if (deq_instr !== 32'h1000_0040) begin bad++; $display("FAIL redir_instr0: got %h want 10000040", deq_instr); end
    @(negedge clk); #1;
    total++; if (deq_pc !== 32'h104) begin bad++; $display("FAIL redir_pc1: got %h want 00000104", deq_pc); end
    total++; if (deq_instr !== 32'h1000_0041) begin bad++; $display("FAIL redir_instr1: got %h want 10000041", deq_instr); end
  endtask

  task automatic test_redirect_on_return;
    do_reset(1'b1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    total++; if (deq_pc !== 32'h0) begin bad++; $display("FAIL ret_pc0: got %h want 0", deq_pc); end
    @(negedge clk); #1;
    // The fetch of pc 0x8 is returning in this cycle.
    total++; if (deq_pc !== 32'h4) begin bad++; $display("FAIL ret_pc4: got %h want 4", deq_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL ret_redir_valid: got %b want 0", deq_valid); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL ret_count: got %0d want 0", count); end
    @(negedge clk); #1;
    total++; if (deq_valid !== 1'b1) begin bad++; $display("FAIL ret_target_valid: got %b want 1", deq_valid); end
    total++; if (deq_pc !== 32'h200) begin bad++; $display("FAIL ret_target_pc: got %h want 00000200", deq_pc); end
    total++; if (deq_instr !== 32'h1000_0080) begin bad++; $display("FAIL ret_target_instr: got %h want 10000080", deq_instr); end
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    #1;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL async_pre_count: got %0d want 3", count); end
    #1;
    rst = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL async_count: got %0d want 0", count); end
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", deq_valid); end
    total++; if (im_a !== 14'h0000) begin bad++; $display("FAIL async_im_a: got %h want 0000", im_a); end
    deq_ready = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    total++; if (deq_valid !== 1'b0) begin bad++; $display("FAIL async_restart_valid: got %b want 0", deq_valid); end
    @(negedge clk); #1;
    total++; if (deq_pc !== 32'h0) begin bad++; $display("FAIL async_restart_pc: got %h want 0", deq_pc); end
    total++; if (deq_instr !== 32'h1000_0000) begin bad++; $display("FAIL async_restart_instr: got %h want 10000000", deq_instr); end
  endtask

  task automatic test_wrap;
    deq_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_FFFC;
    #1;
    total++; if (im_a !== 14'h3FFF) begin bad++; $display("FAIL wrap_im_a0: got %h want 3fff", im_a); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    total++; if (im_a !== 14'h0000) begin bad++; $display("FAIL wrap_im_a1: got %h want 0000", im_a); end
    @(negedge clk); #1;
    total++; if (deq_pc !== 32'h0000_FFFC) begin bad++; $display("FAIL wrap_pc0: got %h want 0000fffc", deq_pc); end
    total++; if (deq_instr !== 32'h1000_3FFF) begin bad++; $display("FAIL wrap_instr0: got %h want 10003fff", deq_instr); end
    @(negedge clk); #1;
    total++; if (deq_pc !== 32'h0001_0000) begin bad++; $display("FAIL wrap_pc1: got %h want 00010000", deq_pc); end
    total++; if (deq_instr !== 32'h1000_0000) begin bad++; $display("FAIL wrap_instr1: got %h want 10000000", deq_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_then_drain();
    test_redirect_full();
    test_redirect_on_return();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
